// File: rtl/otter_mem_resp.sv
// Unified instruction/data memory for the OTTER core: registered fetch port, byte-lane data port, memory-mapped IO.
// Optional misalignment trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module otter_mem_resp #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        MEM_RDEN1,
    input  logic [13:0] MEM_ADDR1,
    output logic [31:0] MEM_DOUT1,
    input  logic        MEM_RDEN2,
    input  logic        MEM_WE2,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_UNSIGNED,
    output logic [31:0] MEM_DOUT2,
    input  logic [31:0] IO_IN,
    output logic        IO_WR,
    output logic [31:0] IO_ADDR,
    output logic [31:0] IO_DATA,
    output logic        MEM_ERR
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx1;
    logic [AW-1:0] idx2;
    logic          is_io;
    logic          misaligned;
    logic          mem_wr;
    logic          io_wr;
    logic          rd2;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [31:0]   load_val;

    logic [31:0] mem_dout1_q;
    logic [31:0] mem_dout2_q, mem_dout2_d;
    logic        io_wr_q;
    logic [31:0] io_addr_q;
    logic [31:0] io_data_q;

    assign idx1  = AW'(MEM_ADDR1);
    assign idx2  = MEM_ADDR2[AW+1:2];
    assign is_io = (MEM_ADDR2 >= IO_BASE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (MEM_WE2 || MEM_RDEN2) && !is_io &&
                        (((MEM_SIZE == 2'b01) && MEM_ADDR2[0]) ||
                         (MEM_SIZE[1] && (MEM_ADDR2[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign mem_wr = MEM_WE2 && !is_io && !misaligned;
    assign io_wr  = MEM_WE2 && is_io;
    // A write on port 2 takes priority over a simultaneous read, so the load register holds.
    assign rd2    = MEM_RDEN2 && !MEM_WE2 && !misaligned;

    always_comb begin
        be    = 4'b1111;
        wdata = MEM_DIN2;
        case (MEM_SIZE)
            2'b00: begin
                be    = 4'b0001 << MEM_ADDR2[1:0];
                wdata = {4{MEM_DIN2[7:0]}};
            end
            2'b01: begin
                be    = MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
                wdata = {2{MEM_DIN2[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = MEM_DIN2;
            end
        endcase
    end

    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        rword  = mem[idx2];
        lane_b = rword[8*MEM_ADDR2[1:0] +: 8];
        lane_h = MEM_ADDR2[1] ? rword[31:16] : rword[15:0];
        case (MEM_SIZE)
            2'b00:   load_val = {{24{lane_b[7] & ~MEM_UNSIGNED}}, lane_b};
            2'b01:   load_val = {{16{lane_h[15] & ~MEM_UNSIGNED}}, lane_h};
            default: load_val = rword;
        endcase
    end

    always_comb begin
        mem_dout2_d = mem_dout2_q;
        if (rd2) begin
            mem_dout2_d = is_io ? IO_IN : load_val;
        end
    end

    // NOTE: the memory array has no reset; contents survive RST, and only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (!RST && mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx2][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking reads of mem here see the pre-write word, giving read-first behaviour on a same-edge write.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            mem_dout1_q <= '0;
            mem_dout2_q <= '0;
            io_wr_q     <= 1'b0;
            io_addr_q   <= '0;
            io_data_q   <= '0;
        end else begin
            if (MEM_RDEN1) begin
                mem_dout1_q <= mem[idx1];
            end
            mem_dout2_q <= mem_dout2_d;
            io_wr_q     <= io_wr;
            if (io_wr) begin
                io_addr_q <= MEM_ADDR2;
                io_data_q <= MEM_DIN2;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic mem_err_q;
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            mem_err_q <= 1'b0;
        end else if (misaligned) begin
            mem_err_q <= 1'b1;
        end
    end
    assign MEM_ERR = mem_err_q;
`else
    assign MEM_ERR = 1'b0;
`endif

    assign MEM_DOUT1 = mem_dout1_q;
    assign MEM_DOUT2 = mem_dout2_q;
    assign IO_WR     = io_wr_q;
    assign IO_ADDR   = io_addr_q;
    assign IO_DATA   = io_data_q;

endmodule

// File: doc/otter_mem_resp.md
OTTER_MEM_RESP -- requirements
Module: otter_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 16384, giving the number of 32-bit words in unified instruction/data memory.
REQ-002 The block SHALL have parameter IO_BASE, default 32'h1100_0000; any port-2 byte address >= IO_BASE maps to IO, not memory.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port MEM_RDEN1, input, 1 bit: instruction fetch strobe from the control unit.
REQ-006 The block SHALL have port MEM_ADDR1, input, 14 bits: instruction word address, equal to PC[15:2].
REQ-007 The block SHALL have port MEM_DOUT1, output, 32 bits: registered instruction word.
REQ-008 The block SHALL have port MEM_RDEN2, input, 1 bit: data read strobe.
REQ-009 The block SHALL have port MEM_WE2, input, 1 bit: data write strobe.
REQ-010 The block SHALL have port MEM_ADDR2, input, 32 bits: data byte address.
REQ-011 The block SHALL have port MEM_DIN2, input, 32 bits: store data, right-justified.
REQ-012 The block SHALL have port MEM_SIZE, input, 2 bits: access size, 00 = byte, 01 = half, 10 or 11 = word.
REQ-013 The block SHALL have port MEM_UNSIGNED, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads (funct3[2]).
REQ-014 The block SHALL have port MEM_DOUT2, output, 32 bits: registered, extended load data.
REQ-015 The block SHALL have port IO_IN, input, 32 bits: IO read data.
REQ-016 The block SHALL have ports IO_WR (output, 1 bit), IO_ADDR (output, 32 bits) and IO_DATA (output, 32 bits): registered IO write strobe, address and data.
REQ-017 The block SHALL have port MEM_ERR, output, 1 bit: sticky misalignment flag.

Function
REQ-018 When MEM_RDEN1=1 at a clock edge, MEM_DOUT1 SHALL load mem[MEM_ADDR1] (1-cycle latency); when MEM_RDEN1=0 it SHALL hold its value.
REQ-019 Port 2 SHALL compute the word index as MEM_ADDR2[$clog2(DEPTH_WORDS)+1:2] and ignore higher bits below IO_BASE.
REQ-020 A memory read (MEM_RDEN2=1, address below IO_BASE) SHALL load MEM_DOUT2 with the lane-extracted value: byte lane MEM_ADDR2[1:0] or half lane MEM_ADDR2[1], extended per MEM_UNSIGNED.
REQ-021 An IO read SHALL load MEM_DOUT2 with IO_IN as sampled at that edge; MEM_SIZE and MEM_UNSIGNED are ignored.
REQ-022 A memory write SHALL update only the addressed byte lanes: byte writes DIN2[7:0] to lane ADDR2[1:0], half writes DIN2[15:0] to lane ADDR2[1], word writes all lanes.
REQ-023 An IO write SHALL leave memory unchanged and SHALL register IO_ADDR=MEM_ADDR2 and IO_DATA=MEM_DIN2 (full word); IO_WR SHALL be high for exactly the next cycle, and IO_ADDR/IO_DATA SHALL hold until the next IO write.
REQ-024 When MEM_RDEN1 and MEM_WE2 target the same word at the same edge, MEM_DOUT1 SHALL return the pre-write data (read-first).
REQ-025 When MEM_WE2 and MEM_RDEN2 are both asserted, the write SHALL be performed and MEM_DOUT2 SHALL hold (write priority).
REQ-026 Back-to-back accesses on consecutive cycles SHALL be supported with no wait states.

Reset
REQ-027 Asserting RST SHALL immediately clear MEM_DOUT1, MEM_DOUT2, IO_ADDR, IO_DATA, IO_WR and MEM_ERR to 0.
REQ-028 While RST=1, all reads and writes SHALL be suppressed, including a write pending at the same edge; memory contents SHALL be retained.
REQ-029 On the first edge after RST deasserts, strobes SHALL be serviced normally.

Configuration
REQ-030 With macro MEM_MISALIGN_TRAP_EN defined, a memory-region half access with ADDR2[0]=1, or word access with ADDR2[1:0]!=0, SHALL suppress the write, hold MEM_DOUT2, and set MEM_ERR (sticky until RST).
REQ-031 With MEM_MISALIGN_TRAP_EN undefined, misaligned low address bits SHALL be ignored (half uses lane ADDR2[1], word is forced aligned) and MEM_ERR SHALL be tied 0.

Verification
REQ-032 Scenario: mem[0]=32'h00000013, RST pulse, then MEM_RDEN1 with MEM_ADDR1=0 -> all outputs 0 during reset; MEM_DOUT1=32'h00000013 one edge after the strobe.
REQ-033 Scenario: sw 32'hDEADBEEF to 0x100 -> lb 0x103 gives 32'hFFFFFFDE; lbu 0x103 gives 32'h000000DE; lh 0x102 gives 32'hFFFFDEAD.
REQ-034 Scenario: memory holds 32'hDEADBEEF at 0x100; sb 8'h55 to 0x101, then lw 0x100 -> 32'hDEAD55EF.
REQ-035 Scenario: sw 32'hF to 0x11000020 -> IO_WR=1 for exactly one cycle, IO_ADDR=32'h11000020, IO_DATA=32'hF, memory unchanged; lw 0x11000000 with IO_IN=32'hA5 -> MEM_DOUT2=32'hA5.
REQ-036 Scenario: fetch of word 0x40 at the same edge as sw 32'h1 to byte address 0x100 -> MEM_DOUT1 holds the old word; the next fetch returns 32'h1.
REQ-037 Scenario: sw to 0x102 -> with MEM_ERR_TRAP macro defined (MEM_MISALIGN_TRAP_EN), MEM_ERR=1 and word 0x100 unchanged; without it, word 0x100 is written and MEM_ERR=0.
